// File: rtl/timer_cmp_irq_if.sv
// rtl/timer_cmp_irq_if.sv - Avalon-MM register bus bundle for the timer compare/interrupt stage
//
// Signals: address[2:0] word address, writedata[31:0], write/read strobes qualified by
// chipselect, readdata[31:0] registered read data, waitrequest (always 0 from the slave).
interface timer_cmp_irq_if;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic        chipselect;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, writedata, write, read, chipselect,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, write, read, chipselect,
        output readdata, waitrequest
    );
endinterface

// File: rtl/timer_cmp_irq.sv
// rtl/timer_cmp_irq.sv - Compare/interrupt stage downstream of the free-running timer
//
// Ports:
//   clock   - system clock
//   resetn  - synchronous, active-low reset
//   count   - live 32-bit timer count
//   bus     - Avalon-MM slave (timer_cmp_irq_if.slave), zero wait states, 1-cycle read latency
//   irq     - level interrupt, |(pend & ie)
// Map: 0 CTRL, 1 STATUS (W1C), 2 CMP0, 3 PER0, 4 CMP1, 5 PER1, 6 COUNT snapshot, 7 zero.
module timer_cmp_irq #(
    parameter int NCH = 2
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [31:0]    count,
    timer_cmp_irq_if.slave bus,
    output logic           irq
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } ch_state_t;

    ch_state_t      state [NCH];
    logic [NCH-1:0] en;
    logic [NCH-1:0] periodic;
    logic [NCH-1:0] ie;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] ovr;
    logic [31:0]    cmp [NCH];
    logic [31:0]    per [NCH];
    logic [31:0]    prev_cnt;
    logic [31:0]    readdata_q;

    logic           wr;
    logic           rd;
    logic           wr_ctrl;
    logic           wr_stat;
    logic [NCH-1:0] wr_cmp;
    logic [NCH-1:0] wr_per;
    logic [NCH-1:0] fire;
    logic [NCH-1:0] en_nx;
    logic [31:0]    rdata;

    assign wr      = bus.write & bus.chipselect;
    assign rd      = bus.read & bus.chipselect;
    assign wr_ctrl = wr && (bus.address == 3'd0);
    assign wr_stat = wr && (bus.address == 3'd1);

    assign bus.readdata    = readdata_q;
    assign bus.waitrequest = 1'b0;
    assign irq             = |(pend & ie);

    // A hit needs the count to have just stepped, so a prescaled count that
    // holds for many cycles fires once. A CMP write in the hit cycle wins.
    always_comb begin
        wr_cmp = '0;
        wr_per = '0;
        fire   = '0;
        en_nx  = en;
        for (int n = 0; n < NCH; n++) begin
            wr_cmp[n] = wr && (bus.address == 3'(2 + 2 * n));
            wr_per[n] = wr && (bus.address == 3'(3 + 2 * n));
            fire[n]   = en[n] && (state[n] == ARMED) && (count == cmp[n])
                        && (prev_cnt != count) && !wr_cmp[n];
            if (wr_ctrl) begin
                en_nx[n] = bus.writedata[n];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            3'd0: begin
                for (int n = 0; n < NCH; n++) begin
                    rdata[n]      = en[n];
                    rdata[8 + n]  = periodic[n];
                    rdata[16 + n] = ie[n];
                end
            end
            3'd1: begin
                for (int n = 0; n < NCH; n++) begin
                    rdata[n]     = pend[n];
                    rdata[8 + n] = ovr[n];
                end
            end
            3'd6: rdata = count;
            default: begin
                // Slots of absent channels never match and read back as 0.
                for (int n = 0; n < NCH; n++) begin
                    if (bus.address == 3'(2 + 2 * n)) rdata = cmp[n];
                    if (bus.address == 3'(3 + 2 * n)) rdata = per[n];
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            en         <= '0;
            periodic   <= '0;
            ie         <= '0;
            pend       <= '0;
            ovr        <= '0;
            prev_cnt   <= '0;
            readdata_q <= '0;
            for (int n = 0; n < NCH; n++) begin
                state[n] <= IDLE;
                cmp[n]   <= '0;
                per[n]   <= '0;
            end
        end else begin
            prev_cnt <= count;
            if (rd) begin
                readdata_q <= rdata;
            end
            if (wr_ctrl) begin
                for (int n = 0; n < NCH; n++) begin
                    en[n]       <= bus.writedata[n];
                    periodic[n] <= bus.writedata[8 + n];
                    ie[n]       <= bus.writedata[16 + n];
                end
            end
            for (int n = 0; n < NCH; n++) begin
                // Set beats W1C clear when both land in the same cycle.
                pend[n] <= fire[n] | (pend[n] & ~(wr_stat & bus.writedata[n]));
                ovr[n]  <= (fire[n] & pend[n]) | (ovr[n] & ~(wr_stat & bus.writedata[8 + n]));
                if (wr_per[n]) begin
                    per[n] <= bus.writedata;
                end
                // Advance uses the current per, even if PER is written this cycle.
                if (wr_cmp[n]) begin
                    cmp[n] <= bus.writedata;
                end else if (fire[n] && periodic[n]) begin
                    cmp[n] <= cmp[n] + per[n];
                end
                if (!en_nx[n]) begin
                    state[n] <= IDLE;
                end else begin
                    case (state[n])
                        IDLE:    state[n] <= ARMED;
                        ARMED:   if (fire[n] && !periodic[n]) state[n] <= DONE;
                        DONE:    if (wr_cmp[n]) state[n] <= ARMED;
                        default: state[n] <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
